// File: rtl/seven_seg_decoder.sv
// Passive read-back decoder for the scanned seven-segment bus: de-glitches each
// scan slot, maps lit glyphs back to nibbles and publishes complete 16-bit frames.
module seven_seg_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  anode_L,
   input  logic [6:0]  seg_L,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        err
);
   localparam int         NUM_DIGITS = 4;
   localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);

   typedef struct packed {
      logic [3:0] anode_L;
      logic [6:0] seg_L;
   } sample_t;

   typedef struct packed {
      logic       ok;
      logic [3:0] nib;
   } glyph_t;

   sample_t                          s, s_in;
   logic [7:0]                       cnt;
   logic                             accept;
   logic [NUM_DIGITS-1:0]            sel;
   logic                             blank, one_hot;
   logic [1:0]                       sel_idx;
   glyph_t                           glyph;
   logic                             capture, bad, frame_done;
   logic [NUM_DIGITS-1:0]            seen, seen_nxt;
   logic [NUM_DIGITS-1:0][3:0]       digits, digits_nxt;

   assign s_in = {anode_L, seg_L};

   // Fires once per stable window: only on the cnt step into saturation.
   assign accept = (s_in == s) && (cnt == CNT_MAX - 8'd1);

   assign sel     = ~s.anode_L;
   assign blank   = (sel == '0);
   assign one_hot = !blank && ((sel & (sel - NUM_DIGITS'(1))) == '0);

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (sel[i]) sel_idx = 2'(i);
   end

   // Glyph table is kept active-high g..a; the bus is active low.
   always_comb begin
      glyph = '{ok: 1'b1, nib: 4'h0};
      case (~s.seg_L)
         7'h3F: glyph.nib = 4'h0;
         7'h06: glyph.nib = 4'h1;
         7'h5B: glyph.nib = 4'h2;
         7'h4F: glyph.nib = 4'h3;
         7'h66: glyph.nib = 4'h4;
         7'h6D: glyph.nib = 4'h5;
         7'h7D: glyph.nib = 4'h6;
         7'h07: glyph.nib = 4'h7;
         7'h7F: glyph.nib = 4'h8;
         7'h6F: glyph.nib = 4'h9;
         7'h77: glyph.nib = 4'hA;
         7'h7C: glyph.nib = 4'hB;
         7'h39: glyph.nib = 4'hC;
         7'h5E: glyph.nib = 4'hD;
         7'h79: glyph.nib = 4'hE;
         7'h71: glyph.nib = 4'hF;
         default: glyph.ok = 1'b0;
      endcase
   end

   assign capture = accept && one_hot && glyph.ok;
   assign bad     = accept && !blank && !capture;

   always_comb begin
      digits_nxt = digits;
      seen_nxt   = seen;
      if (capture) begin
         digits_nxt[sel_idx] = glyph.nib;
         seen_nxt            = seen | sel;
      end
   end

   assign frame_done = capture && (seen_nxt == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s           <= '{anode_L: 4'hF, seg_L: 7'h7F};
         cnt         <= '0;
         seen        <= '0;
         digits      <= '0;
         value       <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (s_in != s) begin
            s   <= s_in;
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
         end
         digits      <= digits_nxt;
         seen        <= frame_done ? '0 : seen_nxt;
         if (frame_done) value <= digits_nxt;
         frame_valid <= frame_done;
         err         <= bad;
      end
   end
endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: run-length behavioural model checked every cycle,
// directed scenarios pinned with literal expectations, then random scan traffic.
module tb_seven_seg_decoder;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  anode_L = 4'hF;
   logic [6:0]  seg_L = 7'h7F;
   logic [15:0] value;
   logic        frame_valid, err;

   seven_seg_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .anode_L(anode_L), .seg_L(seg_L),
      .value(value), .frame_valid(frame_valid), .err(err)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_checks = 0;
   int n_err    = 0;
   int fv_cnt   = 0;
   int err_cnt  = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] dig_an(input int d);
      logic [3:0] a;
      a    = 4'hF;
      a[d] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] seg_of(input int n);
      return ~glyph[n];
   endfunction

   // Behavioural model: a pattern is accepted when it has been seen on SC+1 edges in a row.
   logic [10:0] m_prev  = 11'h7FF;
   int          m_run   = 1;
   logic [3:0]  m_seen  = '0;
   logic [3:0]  m_dig [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
   logic [15:0] m_value = '0;
   logic        m_fv    = 1'b0;
   logic        m_err   = 1'b0;

   task automatic model_accept(input logic [3:0] an, input logic [6:0] sg);
      int lit = 0;
      int d   = 0;
      int nib = -1;
      for (int i = 0; i < 4; i++) if (!an[i]) begin lit++; d = i; end
      for (int n = 0; n < 16; n++) if (seg_of(n) == sg) nib = n;
      if (lit == 0) return;
      if (lit > 1 || nib < 0) begin
         m_err = 1'b1;
         return;
      end
      m_dig[d]  = 4'(nib);
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
         m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
         m_fv    = 1'b1;
         m_seen  = '0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_prev  = 11'h7FF;
         m_run   = 1;
         m_seen  = '0;
         m_dig   = '{4'h0, 4'h0, 4'h0, 4'h0};
         m_value = '0;
         m_fv    = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_fv  = 1'b0;
         m_err = 1'b0;
         if ({anode_L, seg_L} == m_prev) m_run++;
         else begin
            m_prev = {anode_L, seg_L};
            m_run  = 1;
         end
         if (m_run == SC + 1) model_accept(m_prev[10:7], m_prev[6:0]);
      end
   end

   always @(negedge clk)
      if (cmp_en) check("model_cycle", {13'h0, value, frame_valid, err}, {13'h0, m_value, m_fv, m_err});

   always @(posedge clk) begin
      #1;
      if (frame_valid === 1'b1) fv_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic slot(input logic [3:0] an, input logic [6:0] sg, input int n);
      @(negedge clk);
      anode_L = an;
      seg_L   = sg;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int fv0, er0;
      logic [3:0] an;
      logic [6:0] sg;

      repeat (3) @(negedge clk);
      rst    = 1'b0;
      cmp_en = 1'b1;
      check("reset_value", {16'h0, value}, 32'h0);
      check("reset_fv", {31'h0, frame_valid}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);

      // Normal frame 0x4321 with pulse position pinned inside the digit-3 slot.
      fv0 = fv_cnt;
      for (int d = 0; d < 3; d++) slot(dig_an(d), seg_of(d + 1), 10);
      check("seg_code_1", {25'h0, seg_of(1)}, 32'h79);
      @(negedge clk);
      anode_L = dig_an(3);
      seg_L   = 7'h19;
      for (int j = 1; j < 10; j++) begin
         @(negedge clk);
         check("fv_timing", {31'h0, frame_valid}, (j == 5) ? 32'h1 : 32'h0);
      end
      check("normal_value", {16'h0, value}, 32'h4321);
      check("normal_frames", fv_cnt - fv0, 32'd1);

      // Glitch rejection: short digit-2 slot must not complete the frame.
      fv0 = fv_cnt;
      slot(dig_an(0), seg_of(5), 10);
      slot(dig_an(1), seg_of(6), 10);
      slot(dig_an(2), seg_of(14), 3);
      slot(dig_an(3), seg_of(8), 10);
      check("glitch_no_frame", fv_cnt - fv0, 32'd0);
      check("glitch_hold", {16'h0, value}, 32'h4321);
      slot(dig_an(2), seg_of(7), 10);
      check("glitch_frame", fv_cnt - fv0, 32'd1);
      check("glitch_value", {16'h0, value}, 32'h8765);

      // Error cases.
      fv0 = fv_cnt;
      er0 = err_cnt;
      slot(dig_an(1), 7'h7F, 10);
      check("err_all_off", err_cnt - er0, 32'd1);
      slot(4'b1100, seg_of(3), 10);
      check("err_two_anodes", err_cnt - er0, 32'd2);
      slot(4'hF, 7'h7F, 10);
      check("blank_no_err", err_cnt - er0, 32'd2);
      check("err_no_frame", fv_cnt - fv0, 32'd0);
      check("err_value_hold", {16'h0, value}, 32'h8765);

      // Reset mid-frame discards partial captures.
      slot(dig_an(0), seg_of(1), 10);
      slot(dig_an(1), seg_of(2), 10);
      @(negedge clk);
      anode_L = 4'hF;
      seg_L   = 7'h7F;
      #2 rst = 1'b1;
      #1;
      check("async_rst_value", {16'h0, value}, 32'h0);
      check("async_rst_fv", {31'h0, frame_valid}, 32'h0);
      check("async_rst_err", {31'h0, err}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fv0 = fv_cnt;
      slot(dig_an(0), seg_of(10), 10);
      slot(dig_an(1), seg_of(11), 10);
      slot(dig_an(2), seg_of(12), 10);
      check("rst_partial_value", {16'h0, value}, 32'h0);
      check("rst_partial_frames", fv_cnt - fv0, 32'd0);
      slot(dig_an(3), seg_of(13), 10);
      check("rst_frame_value", {16'h0, value}, 32'hDCBA);
      check("rst_frame_count", fv_cnt - fv0, 32'd1);

      // Overwrite: newest capture of digit 0 wins.
      fv0 = fv_cnt;
      slot(dig_an(0), seg_of(5), 10);
      slot(4'hF, 7'h7F, 10);
      slot(dig_an(0), seg_of(6), 10);
      slot(dig_an(1), seg_of(7), 10);
      slot(dig_an(2), seg_of(8), 10);
      slot(dig_an(3), seg_of(9), 10);
      check("overwrite_value", {16'h0, value}, 32'h9876);
      check("overwrite_frames", fv_cnt - fv0, 32'd1);

      // Random scan traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: an = dig_an(int'($urandom_range(0, 3)));
            6:                an = 4'hF;
            default:          an = 4'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) sg = 7'($urandom);
         else sg = seg_of(int'($urandom_range(0, 15)));
         slot(an, sg, int'($urandom_range(1, 12)));
      end
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
